// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle datapath and its controller.
// The datapath side is the master; the controller is the slave.
interface multicycle_controller_if;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] cond;
  logic [3:0] alu_flags;
  logic       pc_write;
  logic       ir_write;
  logic       adr_src;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [1:0] imm_src;
  logic [1:0] reg_src;
  logic [2:0] alu_ctl;
  logic [3:0] state;

  modport master (
    output op, funct, rd, cond, alu_flags,
    input  pc_write, ir_write, adr_src,
    input  mem_write, reg_write,
    input  alu_src_a, alu_src_b, result_src,
    input  imm_src, reg_src, alu_ctl, state
  );

  modport slave (
    input  op, funct, rd, cond, alu_flags,
    output pc_write, ir_write, adr_src,
    output mem_write, reg_write,
    output alu_src_a, alu_src_b, result_src,
    output imm_src, reg_src, alu_ctl, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle ARM controller: Moore main FSM, instruction
// decoder and NZCV condition logic gating architectural writes.
module multicycle_controller (
  input logic clk,
  input logic reset,
  multicycle_controller_if.slave bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_flags;

  logic [2:0] w_dec_alu;
  logic       w_no_write;
  logic       w_cv_upd;
  logic       w_condex;
  logic       w_rd15;
  logic       w_exec;
  logic       w_upd_nz;
  logic       w_upd_cv;

  logic       w_pc_write;
  logic       w_ir_write;
  logic       w_adr_src;
  logic       w_mem_write;
  logic       w_reg_write;
  logic [1:0] w_src_a;
  logic [1:0] w_src_b;
  logic [1:0] w_res_src;
  logic [2:0] w_alu_ctl;

  always_comb begin
    w_dec_alu  = ALU_ADD;
    w_no_write = 1'b0;
    w_cv_upd   = 1'b0;
    case (bus.funct[4:1])
      4'b0100: begin
        w_dec_alu = ALU_ADD;
        w_cv_upd  = 1'b1;
      end
      4'b0010: begin
        w_dec_alu = ALU_SUB;
        w_cv_upd  = 1'b1;
      end
      4'b0000: w_dec_alu = ALU_AND;
      4'b1100: w_dec_alu = ALU_ORR;
      4'b1010: begin
        w_dec_alu  = ALU_SUB;
        w_no_write = 1'b1;
        w_cv_upd   = 1'b1;
      end
      default: begin
        w_dec_alu  = ALU_ADD;
        w_no_write = 1'b1;
      end
    endcase
  end

  // r_flags is {N,Z,C,V}
  always_comb begin
    w_condex = 1'b0;
    case (bus.cond)
      4'b0000: w_condex = r_flags[2];
      4'b0001: w_condex = ~r_flags[2];
      4'b0010: w_condex = r_flags[1];
      4'b0011: w_condex = ~r_flags[1];
      4'b0100: w_condex = r_flags[3];
      4'b0101: w_condex = ~r_flags[3];
      4'b0110: w_condex = r_flags[0];
      4'b0111: w_condex = ~r_flags[0];
      4'b1000: w_condex = r_flags[1] & ~r_flags[2];
      4'b1001: w_condex = ~r_flags[1] | r_flags[2];
      4'b1010: w_condex = r_flags[3] == r_flags[0];
      4'b1011: w_condex = r_flags[3] != r_flags[0];
      4'b1100: w_condex = ~r_flags[2] &
                          (r_flags[3] == r_flags[0]);
      4'b1101: w_condex = r_flags[2] |
                          (r_flags[3] != r_flags[0]);
      4'b1110: w_condex = 1'b1;
      default: w_condex = 1'b0;
    endcase
  end

  assign w_rd15   = bus.rd == 4'hf;
  assign w_exec   = (r_state == S_EXECR) |
                    (r_state == S_EXECI);
  assign w_upd_nz = w_exec & bus.funct[0] & w_condex;
  assign w_upd_cv = w_upd_nz & w_cv_upd;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_flags <= 4'b0000;
    end else begin
      r_state <= w_next;
      if (w_upd_nz) r_flags[3:2] <= bus.alu_flags[3:2];
      if (w_upd_cv) r_flags[1:0] <= bus.alu_flags[1:0];
    end
  end

  always_comb begin
    w_next      = S_FETCH;
    w_pc_write  = 1'b0;
    w_ir_write  = 1'b0;
    w_adr_src   = 1'b0;
    w_mem_write = 1'b0;
    w_reg_write = 1'b0;
    w_src_a     = 2'b00;
    w_src_b     = 2'b00;
    w_res_src   = 2'b00;
    w_alu_ctl   = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_src_a    = 2'b01;
        w_src_b    = 2'b10;
        w_res_src  = 2'b10;
        w_ir_write = 1'b1;
        w_pc_write = 1'b1;
        w_next     = S_DECODE;
      end
      S_DECODE: begin
        w_src_a   = 2'b01;
        w_src_b   = 2'b10;
        w_res_src = 2'b10;
        case (bus.op)
          2'b01:   w_next = S_MEMADR;
          2'b00:   w_next = bus.funct[5] ? S_EXECI
                                         : S_EXECR;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        w_src_b = 2'b01;
        w_next  = bus.funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_adr_src = 1'b1;
        w_next    = S_MEMWB;
      end
      S_MEMWB: begin
        w_res_src   = 2'b01;
        w_reg_write = w_condex;
        w_pc_write  = w_condex & w_rd15;
      end
      S_MEMWR: begin
        w_adr_src   = 1'b1;
        w_mem_write = w_condex;
      end
      S_EXECR: begin
        w_alu_ctl = w_dec_alu;
        w_next    = S_ALUWB;
      end
      S_EXECI: begin
        w_src_b   = 2'b01;
        w_alu_ctl = w_dec_alu;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = w_condex & ~w_no_write;
        w_pc_write  = w_condex & ~w_no_write & w_rd15;
      end
      S_BRANCH: begin
        w_src_a    = 2'b10;
        w_src_b    = 2'b01;
        w_res_src  = 2'b10;
        w_pc_write = w_condex;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Write enables are held off for the whole time reset is low
  assign bus.pc_write   = w_pc_write & reset;
  assign bus.ir_write   = w_ir_write & reset;
  assign bus.mem_write  = w_mem_write & reset;
  assign bus.reg_write  = w_reg_write & reset;
  assign bus.adr_src    = w_adr_src;
  assign bus.alu_src_a  = w_src_a;
  assign bus.alu_src_b  = w_src_b;
  assign bus.result_src = w_res_src;
  assign bus.alu_ctl    = w_alu_ctl;
  assign bus.imm_src    = bus.op;
  assign bus.reg_src    = {bus.op == 2'b01,
                           bus.op == 2'b10};
  assign bus.state      = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: state sequences,
// condition gating, flag updates and reset behaviour.
module tb_multicycle_controller;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [1:0] op,
                       input logic [5:0] f,
                       input logic [3:0] r,
                       input logic [3:0] c);
    bus.op    = op;
    bus.funct = f;
    bus.rd    = r;
    bus.cond  = c;
  endtask

  task automatic dp(input string tag,
                    input logic [5:0] f,
                    input logic [3:0] r,
                    input logic [3:0] c,
                    input logic [3:0] fl,
                    input logic [3:0] es,
                    input logic [2:0] ea,
                    input logic erw,
                    input logic epw);
    instr(2'b00, f, r, c);
    bus.alu_flags = fl;
    chk({tag, "_s0"}, bus.state, 0);
    tick();
    chk({tag, "_s1"}, bus.state, 1);
    tick();
    chk({tag, "_sx"}, bus.state, es);
    chk({tag, "_alu"}, bus.alu_ctl, ea);
    tick();
    chk({tag, "_s8"}, bus.state, 8);
    chk({tag, "_rw"}, bus.reg_write, erw);
    chk({tag, "_pw"}, bus.pc_write, epw);
    tick();
  endtask

  task automatic br(input string tag,
                    input logic [3:0] c,
                    input logic epw);
    instr(2'b10, 6'b000000, 4'h0, c);
    chk({tag, "_s0"}, bus.state, 0);
    tick();
    tick();
    chk({tag, "_s9"}, bus.state, 9);
    chk({tag, "_pw"}, bus.pc_write, epw);
    chk({tag, "_a"}, bus.alu_src_a, 2);
    tick();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b0;
    bus.alu_flags = 4'b0000;
    instr(2'b00, 6'b101001, 4'h1, 4'he);
    tick();
    tick();
    chk("rst_state", bus.state, 0);
    chk("rst_irw", bus.ir_write, 0);
    chk("rst_pcw", bus.pc_write, 0);
    reset = 1'b1;
    #1;
    chk("rel_irw", bus.ir_write, 1);
    chk("rel_pcw", bus.pc_write, 1);
    chk("rel_srcb", bus.alu_src_b, 2);

    // ADDS imm, flags 0110
    dp("adds", 6'b101001, 4'h1, 4'he, 4'b0110,
       4'd7, 3'b000, 1'b1, 1'b0);
    br("bcs1", 4'b0010, 1'b1);
    br("bvs0", 4'b0110, 1'b0);
    // CMPS Z=1; CV loaded so C drops
    dp("cmpz", 6'b010101, 4'h0, 4'he, 4'b0100,
       4'd6, 3'b001, 1'b0, 1'b0);
    br("beq1", 4'b0000, 1'b1);
    br("bcs0", 4'b0010, 1'b0);
    dp("cmpnz", 6'b010101, 4'h0, 4'he, 4'b0000,
       4'd6, 3'b001, 1'b0, 1'b0);
    br("beq0", 4'b0000, 1'b0);
    br("bne1", 4'b0001, 1'b1);
    // ANDS keeps CV: flags 0010 -> 0110
    dp("addc", 6'b101001, 4'h2, 4'he, 4'b0010,
       4'd7, 3'b000, 1'b1, 1'b0);
    dp("ands", 6'b000001, 4'h2, 4'he, 4'b0101,
       4'd6, 3'b010, 1'b1, 1'b0);
    br("bcs_and", 4'b0010, 1'b1);
    br("bvs_and", 4'b0110, 1'b0);
    br("bhi_and", 4'b1000, 1'b0);
    dp("orrpc", 6'b011000, 4'hf, 4'he, 4'b1111,
       4'd6, 3'b011, 1'b1, 1'b1);
    dp("never", 6'b001000, 4'h3, 4'hf, 4'b0000,
       4'd6, 3'b000, 1'b0, 1'b0);
    br("beq_keep", 4'b0000, 1'b1);

    // LDR pc
    instr(2'b01, 6'b011001, 4'hf, 4'he);
    chk("ldr_s0", bus.state, 0);
    tick();
    chk("ldr_rsrc", bus.reg_src, 2);
    tick();
    chk("ldr_s2", bus.state, 2);
    chk("ldr_srcb", bus.alu_src_b, 1);
    tick();
    chk("ldr_s3", bus.state, 3);
    chk("ldr_adr", bus.adr_src, 1);
    tick();
    chk("ldr_s4", bus.state, 4);
    chk("ldr_rw", bus.reg_write, 1);
    chk("ldr_pw", bus.pc_write, 1);
    chk("ldr_res", bus.result_src, 1);
    tick();

    // STRNE with Z=1
    instr(2'b01, 6'b011000, 4'h2, 4'h1);
    chk("strne_s0", bus.state, 0);
    tick();
    tick();
    tick();
    chk("strne_s5", bus.state, 5);
    chk("strne_mw", bus.mem_write, 0);
    tick();
    chk("strne_back", bus.state, 0);

    // undefined class
    instr(2'b11, 6'b000000, 4'h0, 4'he);
    tick();
    chk("op3_s1", bus.state, 1);
    chk("op3_wr", {bus.pc_write, bus.ir_write,
                   bus.reg_write, bus.mem_write}, 0);
    tick();
    chk("op3_back", bus.state, 0);

    // STR AL, reset in MEMWR
    instr(2'b01, 6'b011000, 4'h2, 4'he);
    tick();
    tick();
    tick();
    chk("str_s5", bus.state, 5);
    chk("str_mw", bus.mem_write, 1);
    reset = 1'b0;
    #1;
    chk("mrst_mw0", bus.mem_write, 0);
    tick();
    chk("mrst_s0", bus.state, 0);
    chk("mrst_mw1", bus.mem_write, 0);
    tick();
    chk("mrst_s0b", bus.state, 0);
    reset = 1'b1;
    #1;
    br("beq_rst", 4'b0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule
